// File: rtl/aes_128_pkg.sv
// ---------------------------------------------------------------------------
// aes_128_pkg
//  Shared definitions for the AES-128 key-schedule generator:
//   - NR / KEY_WORDS defaults (rounds, 64-bit RAM words per key set)
//   - FSM state encoding
//   - RCON round constants and the AES forward S-box table
//   - RotWord helper
// ---------------------------------------------------------------------------
package aes_128_pkg;

   localparam int NR_DEFAULT        = 10;
   localparam int KEY_WORDS_DEFAULT = 2 * (NR_DEFAULT + 1);

   typedef logic [127:0] key_t;
   typedef logic [63:0]  ram_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Round constants; entry i is used when deriving round key i+1.
   localparam logic [7:0] RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // RotWord: cyclic left rotation of a 32-bit word by one byte.
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_128_key_expand_if.sv
// ---------------------------------------------------------------------------
// aes_128_key_expand_if
//  Request / key-RAM write bundle of the key-schedule generator.
//   start      requester -> expander  one-cycle request, sampled in IDLE only
//   key_in     requester -> expander  128-bit cipher key, w0 = key_in[127:96]
//   en_wr      expander  -> RAM       write enable (RAM controller advances address)
//   wr_data    expander  -> RAM       64-bit write data
//   key_ready  expander  -> RAM ctrl  one-cycle pulse after the last word
//   busy       expander  -> requester high from accepted start through key_ready
//  master = requester / RAM side, slave = the expander.
// ---------------------------------------------------------------------------
interface aes_128_key_expand_if;
   import aes_128_pkg::*;

   logic      start;
   key_t      key_in;
   logic      en_wr;
   ram_word_t wr_data;
   logic      key_ready;
   logic      busy;

   modport master (
      output start, key_in,
      input  en_wr, wr_data, key_ready, busy
   );

   modport slave (
      input  start, key_in,
      output en_wr, wr_data, key_ready, busy
   );

endinterface

// File: rtl/aes_128_sbox_word.sv
// ---------------------------------------------------------------------------
// aes_128_sbox_word
//  Four parallel AES S-box lookups on a 32-bit word, registered output
//  (1-cycle latency) so the table can map onto block RAM.
//   clk   in   1   clock
//   en    in   1   capture a new lookup; output holds while low
//   din   in   32  four byte addresses
//   dout  out  32  SubWord(din) from the last enabled cycle
// ---------------------------------------------------------------------------
module aes_128_sbox_word
   import aes_128_pkg::*;
(
   input  logic        clk,
   input  logic        en,
   input  logic [31:0] din,
   output logic [31:0] dout
);

   logic [31:0] dout_q, dout_d;

   always_comb begin
      dout_d = dout_q;
      if (en) begin
         dout_d = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};
      end
   end

   // NOTE: ROM/RAM output registers carry no reset so they map onto block RAM;
   // the value is only consumed one cycle after an enabled lookup.
   always_ff @(posedge clk) begin
      dout_q <= dout_d;
   end

   assign dout = dout_q;

endmodule

// File: rtl/aes_128_key_expand.sv
// ---------------------------------------------------------------------------
// aes_128_key_expand
//  AES-128 key-schedule generator. On an accepted start it writes round keys
//  0..NR into the key RAM as 2*(NR+1) consecutive 64-bit words (low half of
//  each round key first, then high half) and then pulses key_ready.
//   clk    in   1   system clock, rising edge
//   kill   in   1   asynchronous active-high reset
//   bus    slave    start/key_in in; en_wr/wr_data/key_ready/busy out
// ---------------------------------------------------------------------------
module aes_128_key_expand
   import aes_128_pkg::*;
#(
   parameter int NR = NR_DEFAULT
)
(
   input  logic                 clk,
   input  logic                 kill,
   aes_128_key_expand_if.slave  bus
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   state_e      state_q, state_d;
   key_t        rk_q, rk_d;
   logic [3:0]  rnd_q, rnd_d;

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] sbox_out;
   logic        sbox_en;
   logic [7:0]  rcon_byte;
   logic [31:0] t, n0, n1, n2, n3;

   logic        en_wr;
   ram_word_t   wr_data;
   logic        key_ready;
   logic        busy;

   assign w0 = rk_q[127:96];
   assign w1 = rk_q[95:64];
   assign w2 = rk_q[63:32];
   assign w3 = rk_q[31:0];

   // The lookup is issued in WR_LO and its result is consumed in WR_HI;
   // rk is stable across both cycles, so the enable just freezes the output.
   assign sbox_en = (state_q == WR_LO);

   aes_128_sbox_word u_sbox (
      .clk  (clk),
      .en   (sbox_en),
      .din  (rot_word(w3)),
      .dout (sbox_out)
   );

   // Next round key. The guard keeps RCON addressed inside 0..NR-1 even on
   // the last round, where the result is never loaded.
   always_comb begin
      rcon_byte = (rnd_q < LAST_RND) ? RCON[rnd_q] : 8'h00;
      t  = sbox_out ^ {rcon_byte, 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
   end

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      rk_d      = rk_q;
      rnd_d     = rnd_q;
      en_wr     = 1'b0;
      wr_data   = '0;
      key_ready = 1'b0;
      busy      = 1'b1;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (bus.start) begin
               rk_d    = bus.key_in;
               rnd_d   = 4'd0;
               state_d = WR_LO;
            end
         end
         WR_LO: begin
            en_wr   = 1'b1;
            wr_data = rk_q[63:0];
            state_d = WR_HI;
         end
         WR_HI: begin
            en_wr   = 1'b1;
            wr_data = rk_q[127:64];
            if (rnd_q == LAST_RND) begin
               state_d = DONE;
            end else begin
               rk_d    = {n0, n1, n2, n3};
               rnd_d   = rnd_q + 4'd1;
               state_d = WR_LO;
            end
         end
         DONE: begin
            key_ready = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
         state_q <= IDLE;
         rk_q    <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         rnd_q   <= rnd_d;
      end
   end

   // Outputs decode the state directly, so kill silences them without a clock.
   assign bus.en_wr     = en_wr;
   assign bus.wr_data   = wr_data;
   assign bus.key_ready = key_ready;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_aes_128_key_expand.sv
// ---------------------------------------------------------------------------
// tb_aes_128_key_expand
//  Self-checking bench for aes_128_key_expand. The reference model expands
//  the key word by word (FIPS-197 w[0..43]) with an S-box built from GF(2^8)
//  inversion plus the affine map, and RCON built by repeated xtime.
// ---------------------------------------------------------------------------
module tb_aes_128_key_expand;

   localparam int KW = 22;

   logic clk = 1'b0;
   logic kill;

   always #5 clk = ~clk;

   aes_128_key_expand_if bus ();

   aes_128_key_expand dut (
      .clk  (clk),
      .kill (kill),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  sb [256];
   logic [63:0] exp_words [KW];

   bit active = 1'b0;
   int pos    = 0;
   int wr_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h000000};
            rc  = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) begin
         exp_words[2*r]   = {w[4*r+2], w[4*r+3]};
         exp_words[2*r+1] = {w[4*r],   w[4*r+1]};
      end
   endtask

   // Raise start for one cycle (call just after a rising edge) and arm the
   // compare process from the accepting edge on.
   task automatic issue(input logic [127:0] k);
      model(k);
      bus.start  = 1'b1;
      bus.key_in = k;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      active    = 1'b1;
      pos       = 0;
      wr_cnt    = 0;
   endtask

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (active) begin
            pos++;
            if (pos <= KW) begin
               check("en_wr", bus.en_wr, 1'b1);
               check($sformatf("wr_data[%0d]", pos - 1), bus.wr_data, exp_words[pos-1]);
               check("key_ready_during_write", bus.key_ready, 1'b0);
               check("busy_during_write", bus.busy, 1'b1);
               if (bus.en_wr) wr_cnt++;
            end else if (pos == KW + 1) begin
               check("en_wr_at_ready", bus.en_wr, 1'b0);
               check("key_ready", bus.key_ready, 1'b1);
               check("busy_at_ready", bus.busy, 1'b1);
               check("en_wr_count", wr_cnt, KW);
            end else begin
               check("en_wr_after", bus.en_wr, 1'b0);
               check("key_ready_after", bus.key_ready, 1'b0);
               check("busy_after", bus.busy, 1'b0);
               active = 1'b0;
            end
         end else begin
            check("idle_en_wr", bus.en_wr, 1'b0);
            check("idle_key_ready", bus.key_ready, 1'b0);
            check("idle_busy", bus.busy, 1'b0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [127:0] fips_key;
      fips_key   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
      kill       = 1'b1;
      bus.start  = 1'b0;
      bus.key_in = '0;
      build_sbox();

      repeat (3) @(posedge clk);
      #1;
      check("reset_en_wr", bus.en_wr, 1'b0);
      check("reset_key_ready", bus.key_ready, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_wr_data", bus.wr_data, 64'h0);
      @(negedge clk);
      kill = 1'b0;
      @(posedge clk);
      #1;

      // 1: FIPS-197 key, model pinned by literals
      model(fips_key);
      check("model_fips_w0", exp_words[0], 64'habf7158809cf4f3c);
      check("model_fips_w1", exp_words[1], 64'h2b7e151628aed2a6);
      check("model_fips_w2", exp_words[2], 64'h23a339392a6c7605);
      check("model_fips_w20", exp_words[20], 64'he13f0cc8b6630ca6);
      check("model_fips_w21", exp_words[21], 64'hd014f9a8c9ee2589);
      issue(fips_key);
      repeat (24) @(posedge clk);
      #1;

      // 2: all-zero key
      model(128'h0);
      check("model_zero_w0", exp_words[0], 64'h0);
      check("model_zero_w2", exp_words[2], 64'h6263636362636363);
      check("model_zero_w3", exp_words[3], 64'h6263636362636363);
      issue(128'h0);
      repeat (24) @(posedge clk);
      #1;

      // 3: start held every cycle while busy, key_in scrambled
      issue(128'h00112233_44556677_8899aabb_ccddeeff);
      bus.start = 1'b1;
      for (int i = 0; i < 23; i++) begin
         bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      @(posedge clk);
      #1;

      // 4: kill during cycle 10, then a clean rerun
      issue(fips_key);
      repeat (9) @(posedge clk);
      @(negedge clk);
      #2;
      active = 1'b0;
      kill   = 1'b1;
      #1;
      check("kill_en_wr", bus.en_wr, 1'b0);
      check("kill_key_ready", bus.key_ready, 1'b0);
      check("kill_busy", bus.busy, 1'b0);
      @(negedge clk);
      kill = 1'b0;
      @(posedge clk);
      #1;
      issue(fips_key);
      repeat (24) @(posedge clk);
      #1;

      // 5: back-to-back sets, second start in the cycle after key_ready
      issue(128'h000102030405060708090a0b0c0d0e0f);
      repeat (23) @(posedge clk);
      #1;
      issue(128'hffffffff_00000000_a5a5a5a5_5a5a5a5a);
      repeat (24) @(posedge clk);
      #1;

      // 6: random keys
      for (int n = 0; n < 1000; n++) begin
         issue({$urandom(), $urandom(), $urandom(), $urandom()});
         repeat (24) @(posedge clk);
         #1;
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
